// File: rtl/dram_fetch.sv
// Burst read engine: issues single-word DRAM reads under a credit limit and
// streams the returned words, in order, out of an internal FIFO.

// Generic FIFO with a combinational head read.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: a push into a full FIFO is accepted only alongside a pop.
module dram_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   srstn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count MSB alone flags full.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && (!count_q[AW] || do_pop);
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

// Burst fetch controller.
// Latency: first request 1 cycle after start; output 1 cycle after each return.
// Backpressure: requests stop once buffered plus outstanding words fill the FIFO.
module dram_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] dram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);
  localparam int IW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_left_q;
  logic [LEN_WIDTH-1:0]  deliver_left_q;
  logic [IW-1:0]         inflight_q;
  logic [IW-1:0]         inflight_d;
  logic [IW-1:0]         fifo_cnt;
  logic                  ret;
  logic                  pop;
  logic                  accept;
  logic                  issue_ok;
  logic                  credit_ok;
  int                    occ;

  // A pop this cycle frees a slot by the time a new request could return.
  always_comb begin
    ret       = dram_valid && (inflight_q != '0);
    pop       = out_valid && out_ready;
    occ       = int'(fifo_cnt) + int'(inflight_q) - int'(pop);
    credit_ok = occ < DEPTH;
    accept    = (state_q == S_IDLE) && start && (len != '0);
    issue_ok  = (state_q == S_ISSUE) && (issue_left_q != '0) && credit_ok;
    inflight_d = inflight_q + IW'(accept || issue_ok) - IW'(ret);
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      en_q           <= 1'b0;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      inflight_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (pop) deliver_left_q <= deliver_left_q - LEN_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q        <= (len == LEN_WIDTH'(1)) ? S_DRAIN : S_ISSUE;
              en_q           <= 1'b1;
              addr_q         <= base_addr;
              issue_left_q   <= len - LEN_WIDTH'(1);
              deliver_left_q <= len;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          en_q <= issue_ok;
          if (issue_ok) begin
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            issue_left_q <= issue_left_q - LEN_WIDTH'(1);
            if (issue_left_q == LEN_WIDTH'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          en_q <= 1'b0;
          if ((deliver_left_q == '0) || (pop && deliver_left_q == LEN_WIDTH'(1))) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  dram_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .srstn      (srstn),
    .push_i     (ret),
    .push_dat_i (dram_data),
    .pop_i      (pop),
    .head_dat_o (out_data),
    .count_o    (fifo_cnt)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign dram_en_rd   = en_q;
  assign dram_addr_rd = addr_q;
  assign out_valid    = (fifo_cnt != '0);
endmodule

// File: tb/tb_dram_fetch.sv
// Bench for dram_fetch: table of bursts plus hand sequences for stall, protocol error and reset.
module tb_dram_fetch;
  logic        clk = 1'b0;
  logic        srstn;
  logic        start;
  logic [17:0] base_addr;
  logic [15:0] len;
  logic        busy, done, dram_en_rd;
  logic [17:0] dram_addr_rd;
  logic        dram_valid;
  logic [31:0] dram_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  dram_fetch dut (
    .clk(clk), .srstn(srstn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
    .dram_valid(dram_valid), .dram_data(dram_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] base;
    logic [15:0] len;
    int          lat_lo;
    int          lat_hi;
    int          rdy;       // 0 stuck low, 1 stuck high, 2 random
    int          mid_start; // cycle of an extra start pulse, 0 for none
    bit          tput;
    int          exp_n;
    logic [17:0] exp_last;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0;
  int req_n, pop_n, done_n, ov_n, max_out;
  int first_req_cyc, last_req_cyc, last_pop_cyc, done_cyc, last_due;
  int lat_lo = 1, lat_hi = 1, rdy_mode = 1;
  logic [17:0] exp_addr, last_addr;
  logic [17:0] dq_addr[$];
  int          dq_due[$];
  logic [31:0] sb[$];
  bit          prev_stall;
  logic [31:0] prev_dat;
  vec_t        vecs[7];
  bit          got;

  function automatic logic [31:0] word_of(input logic [17:0] a);
    return {a[7:0], 6'h2B, a} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    req_n = 0; pop_n = 0; done_n = 0; ov_n = 0; max_out = 0;
    first_req_cyc = -1; last_req_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    last_due = 0; prev_stall = 1'b0;
    dq_addr.delete(); dq_due.delete(); sb.delete();
  endtask

  // One cycle: observe at the falling edge, then drive inputs for this cycle.
  task automatic tick();
    int due;
    @(negedge clk);
    cyc++;
    if (dram_en_rd) begin
      chk("req_addr", dram_addr_rd, exp_addr);
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      dq_addr.push_back(dram_addr_rd);
      dq_due.push_back(due);
      sb.push_back(word_of(exp_addr));
      exp_addr = exp_addr + 18'd1;
      req_n++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      last_addr = dram_addr_rd;
    end
    if (dq_due.size() > max_out) max_out = dq_due.size();
    if (out_valid) ov_n++;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_dat);
    end
    out_ready = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_word", out_data, 0);
      else chk("out_data", out_data, sb.pop_front());
      pop_n++;
      last_pop_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    dram_valid = 1'b0;
    dram_data  = '0;
    if (dq_due.size() > 0 && dq_due[0] <= cyc) begin
      dram_valid = 1'b1;
      dram_data  = word_of(dq_addr.pop_front());
      void'(dq_due.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    lat_lo = v.lat_lo; lat_hi = v.lat_hi; rdy_mode = v.rdy;
    clear_model();
    exp_addr = v.base;
    start = 1'b1; base_addr = v.base; len = v.len; start_cyc = cyc;
    got = 1'b0;
    for (int i = 1; i < 20000; i++) begin
      tick();
      if (done) begin got = 1'b1; break; end
      start = (v.mid_start != 0) && (i == v.mid_start);
      if (start) begin base_addr = 18'h2AAAA; len = 16'd7; end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_single_cycle", done, 0);
    chk("done_count", done_n, 1);
    chk("req_count", req_n, v.exp_n);
    chk("pop_count", pop_n, v.exp_n);
    chk("sb_empty", sb.size(), 0);
    chk("inflight_bound", max_out <= 8, 1);
    if (v.exp_n > 0) begin
      chk("first_req_lat", first_req_cyc, start_cyc + 1);
      chk("last_addr", last_addr, v.exp_last);
      chk("done_lat", done_cyc, last_pop_cyc + 1);
    end else begin
      chk("len0_done_lat", done_cyc, start_cyc + 1);
      chk("len0_no_valid", ov_n, 0);
    end
    if (v.tput) chk("back_to_back", last_req_cyc - first_req_cyc, v.exp_n - 1);
  endtask

  initial begin
    vecs[0] = '{18'h00100, 16'd25,   1, 1, 1, 0,  1'b1, 25,   18'h00118};
    vecs[1] = '{18'h3FFFE, 16'd4,    1, 3, 1, 0,  1'b0, 4,    18'h00001};
    vecs[2] = '{18'h00055, 16'd0,    1, 1, 1, 0,  1'b0, 0,    18'h00000};
    vecs[3] = '{18'h3FFFF, 16'd1,    2, 2, 1, 0,  1'b0, 1,    18'h3FFFF};
    vecs[4] = '{18'h1F000, 16'd1000, 1, 6, 2, 50, 1'b0, 1000, 18'h1F3E7};
    vecs[5] = '{18'h00010, 16'd60,   4, 6, 2, 10, 1'b0, 60,   18'h0004B};
    vecs[6] = '{18'h0A000, 16'd40,   5, 5, 1, 0,  1'b1, 40,   18'h0A027};

    srstn = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    dram_valid = 1'b0; dram_data = '0; out_ready = 1'b0;
    exp_addr = '0; last_addr = '0; prev_dat = '0;
    clear_model();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en_rd", dram_en_rd, 0);
    chk("rst_addr", dram_addr_rd, 0);
    chk("rst_out_valid", out_valid, 0);
    srstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Consumer stalled: exactly DEPTH requests, then resume.
    lat_lo = 2; lat_hi = 2; rdy_mode = 0;
    clear_model();
    exp_addr = 18'h04000;
    start = 1'b1; base_addr = 18'h04000; len = 16'd20;
    tick();
    start = 1'b0;
    repeat (40) tick();
    chk("stall_req_count", req_n, 8);
    chk("stall_en_low", dram_en_rd, 0);
    chk("stall_full_valid", out_valid, 1);
    rdy_mode = 1;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done) begin got = 1'b1; break; end
    end
    chk("stall_done_seen", got, 1);
    chk("stall_req_total", req_n, 20);
    chk("stall_pop_total", pop_n, 20);
    chk("stall_sb_empty", sb.size(), 0);
    tick();

    // Stray return with nothing outstanding must be dropped.
    dram_valid = 1'b1; dram_data = 32'hDEAD_BEEF;
    tick();
    chk("stray_return_dropped", out_valid, 0);

    // Asynchronous reset in the middle of a burst.
    lat_lo = 1; lat_hi = 6; rdy_mode = 2;
    clear_model();
    exp_addr = 18'h00300;
    start = 1'b1; base_addr = 18'h00300; len = 16'd40;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #3 srstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en_rd", dram_en_rd, 0);
    chk("arst_addr", dram_addr_rd, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_done", done, 0);
    clear_model();
    dram_valid = 1'b0;
    tick(); tick();
    srstn = 1'b1;
    run_vec('{18'h00200, 16'd3, 1, 6, 2, 0, 1'b0, 3, 18'h00202});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
